saturation_timer: RTL and testbench
===================================

# saturation_timer

Loadable down-counter that decrements once per clock while enabled and saturates at zero rather than wrapping. Used by the traffic-light controller as a phase timer. The controller loads a phase duration, enables counting, and watches the zero flag to know when the phase has expired. A separate load input lets an emergency event restart the timer at any time.

## Interface
Parameters:
- BIT_WIDTH, default 6: width of the load value and of the count.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk, input, 1: clock; all state changes on its rising edge.
- rst, input, 1: synchronous active-high reset.
- down, input, 1: count enable; 1 = decrement this cycle, 0 = hold.
- emgLoad, input, 1: emergency/load strobe; 1 = load loadIn this cycle.
- loadIn, input, BIT_WIDTH: value loaded when emgLoad = 1.
- currentCount, output, BIT_WIDTH: registered count value.
- isZero, output, 1: high exactly when currentCount == 0.

## Operation
The count updates on each rising edge of clk. The following priority order applies, highest first:
1. rst = 1: count ← 0.
2. emgLoad = 1: count ← loadIn. This applies regardless of down, and any loadIn value is legal, including 0 and all-ones.
3. down = 1 and count ≠ 0: count ← count − 1.
4. down = 1 and count == 0: count stays 0. This is saturation; the counter never wraps to all-ones.
5. down = 0: count holds.

Output and arithmetic rules:
- isZero is combinational from the count register: isZero = (currentCount == 0). There is no extra register stage.
- All arithmetic is unsigned and BIT_WIDTH wide; no carry-out is exposed.
- Reset values: currentCount = 0, isZero = 1.
- When emgLoad = 1 and rst = 0, down is ignored that cycle. The loaded value is not decremented in the same cycle.
- Loading 0 gives isZero = 1 on the next cycle. Any later down pulses keep the count at 0.

## Timing
- Latency: one cycle from a sampled input to its effect on currentCount. isZero follows currentCount with zero extra delay.
- Loading N and then holding down = 1 gives these values on successive edges: N, N−1, …, 1, 0, 0, …
- isZero rises at the edge that produces 0, which is N edges after the load edge.
- Asserting rst mid-count clears the count on the next edge, whatever emgLoad and down are doing.
- Input changes between edges have no effect. There is no handshake; emgLoad is a level sampled every cycle.

## Structure
- Shared package: BIT_WIDTH default constant (6) and a typedef count_t = logic [BIT_WIDTH-1:0]. Other traffic-light blocks reuse these for phase durations.
- Single module with one always_ff for the count register and a continuous assign for isZero.
- No sub-module is required. The saturating decrement is a small inline expression: count == 0 ? 0 : count − 1.

## Test plan
- Reset: rst = 1 for 2 cycles while emgLoad = 1, loadIn = 10 → currentCount = 0, isZero = 1. rst has priority over load.
- Load and count: emgLoad = 1 with loadIn = 10 for 1 cycle, then down = 1 → counts 10, 9, …, 0. isZero = 1 exactly 10 edges after the load edge.
- Saturation: continue down = 1 for 7 more cycles after reaching 0 → currentCount stays 0 and isZero stays 1. No wrap to 63.
- Hold: load 15, let it reach 12 with down = 1, then set down = 0 for 5 cycles → currentCount stays 12, isZero = 0.
- Emergency reload mid-count: count from 31 down to 20, then pulse emgLoad = 1 with loadIn = 15 while down = 1 → next value is 15, not 14. Decrementing resumes on the following edge.
- Boundary loads: loadIn = 63 (all-ones) → counts from 63 down correctly. loadIn = 0 → isZero = 1 on the next edge.

Source files
------------

// File: rtl/saturation_timer_pkg.sv
// Shared timer types: default count width and the phase-duration type used by
// the traffic-light blocks.
package saturation_timer_pkg;

  localparam int unsigned BIT_WIDTH_DEFAULT = 6;

  typedef logic [BIT_WIDTH_DEFAULT-1:0] count_t;

endpackage : saturation_timer_pkg

// File: rtl/saturation_timer.sv
// Loadable down-counter with saturation at zero. Serves as the phase timer of
// the traffic-light controller; emgLoad restarts the phase at any time.
module saturation_timer
  import saturation_timer_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = BIT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 down,
  input  logic                 emgLoad,
  input  logic [BIT_WIDTH-1:0] loadIn,
  output logic [BIT_WIDTH-1:0] currentCount,
  output logic                 isZero
);

  logic [BIT_WIDTH-1:0] count_d, count_q;

  // Next count: load beats decrement; decrement sticks at zero instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (emgLoad) begin
      count_d = loadIn;
    end else if (down) begin
      count_d = (count_q == '0) ? '0 : count_q - 1'b1;
    end
  end

  // Count register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign currentCount = count_q;
  assign isZero       = (count_q == '0);

endmodule : saturation_timer

// File: tb/tb_saturation_timer.sv
// Directed bench for saturation_timer: a per-cycle reference model compared on
// every falling edge, plus hand-computed literal expectations.
module tb_saturation_timer;

  localparam int unsigned W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         down;
  logic         emgLoad;
  logic [W-1:0] loadIn;
  logic [W-1:0] currentCount;
  logic         isZero;

  int checks   = 0;
  int failures = 0;

  // Reference model state: count as a plain integer, valid once reset seen.
  int model_cnt   = 0;
  bit model_valid = 1'b0;

  saturation_timer #(.BIT_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .down         (down),
    .emgLoad      (emgLoad),
    .loadIn       (loadIn),
    .currentCount (currentCount),
    .isZero       (isZero)
  );

  always #5 clk = ~clk;

  // Reference model: priority rst > load > saturating decrement > hold.
  always @(posedge clk) begin
    if (rst) begin
      model_cnt   <= 0;
      model_valid <= 1'b1;
    end else if (emgLoad) begin
      model_cnt <= int'(loadIn);
    end else if (down) begin
      model_cnt <= (model_cnt > 0) ? model_cnt - 1 : 0;
    end
  end

  task automatic cyc(input logic r, input logic e, input int l, input logic d);
    rst     = r;
    emgLoad = e;
    loadIn  = l[W-1:0];
    down    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input int exp_cnt);
    checks++;
    if (int'(currentCount) != exp_cnt || isZero !== (exp_cnt == 0)) begin
      failures++;
      $display("FAIL %s: got count=%0d isZero=%0b, want count=%0d isZero=%0b",
               name, currentCount, isZero, exp_cnt, (exp_cnt == 0));
    end
  endtask

  initial begin
    rst     = 1'b1;
    emgLoad = 1'b1;
    loadIn  = 6'd10;
    down    = 1'b0;

    // Compare process: every falling edge once the model is meaningful.
    fork
      forever begin
        @(negedge clk);
        if (model_valid) begin
          checks++;
          if (int'(currentCount) != model_cnt || isZero !== (model_cnt == 0)) begin
            failures++;
            $display("FAIL model t=%0t: got count=%0d isZero=%0b, want count=%0d isZero=%0b",
                     $time, currentCount, isZero, model_cnt, (model_cnt == 0));
          end
        end
      end
    join_none

    // Reset beats a concurrent load.
    cyc(1, 1, 10, 0);
    cyc(1, 1, 10, 0);
    check_lit("reset_over_load", 0);

    // Load 10, then count down to zero.
    cyc(0, 1, 10, 1);
    check_lit("load10", 10);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1);
    check_lit("count_at_1", 1);
    cyc(0, 0, 0, 1);
    check_lit("zero_after_10_edges", 0);

    // Saturation: no wrap to 63.
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1);
    check_lit("saturate", 0);

    // Hold at 12.
    cyc(0, 1, 15, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    check_lit("reach12", 12);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    check_lit("hold12", 12);

    // Emergency reload mid-count wins over down.
    cyc(0, 1, 31, 0);
    for (int i = 0; i < 11; i++) cyc(0, 0, 0, 1);
    check_lit("reach20", 20);
    cyc(0, 1, 15, 1);
    check_lit("reload15_not14", 15);
    cyc(0, 0, 0, 1);
    check_lit("resume14", 14);

    // All-ones load.
    cyc(0, 1, 63, 1);
    check_lit("load63", 63);
    cyc(0, 0, 0, 1);
    check_lit("dec62", 62);
    cyc(0, 0, 0, 1);
    check_lit("dec61", 61);

    // Reset mid-count clears regardless of load/down.
    cyc(1, 1, 40, 1);
    check_lit("reset_midcount", 0);

    // Zero load.
    cyc(0, 1, 25, 0);
    check_lit("load25", 25);
    cyc(0, 1, 0, 1);
    check_lit("load0", 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check_lit("load0_saturate", 0);

    // Load is a sampled level: held emgLoad keeps reloading.
    cyc(0, 1, 5, 1);
    cyc(0, 1, 5, 1);
    check_lit("held_load", 5);
    cyc(0, 0, 0, 1);
    check_lit("after_held_load", 4);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_saturation_timer
